// File: rtl/ifetch.sv
// Instruction fetch: up to 2 requests in flight, 2-entry response FIFO, branch/trap redirect with response dropping.
// Fetch-to-decode latency 2 cycles; dec_stall_i holds the output and parks responses. IFETCH_MISALIGN_EXC_EN enables the misaligned-target flag.
module ifetch #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            branch_v_q_i,
  input  logic [XLEN-1:0] branch_target_q_i,
  input  logic            trap_v_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            dec_stall_i,
  output logic [XLEN-1:0] instr_q_o,
  output logic [XLEN-1:0] pc0_q_o,
  output logic            instr_v_q_o,
  output logic            instr_misaligned_q_o
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic            redirect;
  logic            misaligned_tgt;
  logic            halt;
  logic            grant;
  logic            accept;
  logic            push;
  logic            pop;
  logic            req_en;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic [1:0]      fifo_cnt;
  logic            rd_ptr;
  logic            wr_ptr;
  logic [XLEN-1:0] fifo_pc    [2];
  logic [XLEN-1:0] fifo_instr [2];

  always_comb begin
    redirect   = trap_v_i | branch_v_q_i;
    target_raw = trap_v_i ? trap_target_i : branch_target_q_i;
`ifdef IFETCH_MISALIGN_EXC_EN
    target         = target_raw;
    misaligned_tgt = |target_raw[1:0];
`else
    target         = target_raw & ~XLEN'(3);
    misaligned_tgt = 1'b0;
`endif
  end

`ifdef IFETCH_MISALIGN_EXC_EN
  // A misaligned target parks the fetcher until the next redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      halt <= 1'b0;
    else if (redirect) halt <= misaligned_tgt;
  end
`else
  assign halt = 1'b0;
`endif

  // In-flight requests plus parked responses never exceed the FIFO depth.
  assign imem_req_o = req_en & ~halt & ~redirect &
                      (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'd2);
  assign imem_adr_o = fetch_pc;
  assign grant      = imem_req_o & imem_gnt_i;
  assign accept     = imem_rvalid_i & ~redirect & (drop_cnt == 2'd0);
  assign pop        = ~redirect & ~dec_stall_i & (fifo_cnt != 2'd0);
  assign push       = accept & (dec_stall_i | (fifo_cnt != 2'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_en      <= 1'b0;
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      req_en      <= 1'b1;
      outstanding <= outstanding + {1'b0, grant} - {1'b0, imem_rvalid_i};
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // Everything still on the bus is stale; a response landing now is dropped directly.
        drop_cnt <= outstanding - {1'b0, imem_rvalid_i};
      end else begin
        if (grant)                               fetch_pc <= fetch_pc + PC_INC;
        if (accept)                              resp_pc  <= resp_pc + PC_INC;
        if (imem_rvalid_i && drop_cnt != 2'd0)   drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (redirect) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  // Priority: parked responses first, then bypass, else bubble with PC held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q_o            <= NOP_INSTR;
      pc0_q_o              <= '0;
      instr_v_q_o          <= 1'b0;
      instr_misaligned_q_o <= 1'b0;
    end else if (redirect) begin
      instr_q_o            <= NOP_INSTR;
      instr_v_q_o          <= 1'b0;
      instr_misaligned_q_o <= misaligned_tgt;
      if (misaligned_tgt) pc0_q_o <= target;
    end else if (!dec_stall_i) begin
      instr_misaligned_q_o <= 1'b0;
      if (pop) begin
        instr_q_o   <= fifo_instr[rd_ptr];
        pc0_q_o     <= fifo_pc[rd_ptr];
        instr_v_q_o <= 1'b1;
      end else if (accept) begin
        instr_q_o   <= imem_rdata_i;
        pc0_q_o     <= resp_pc;
        instr_v_q_o <= 1'b1;
      end else begin
        instr_q_o   <= NOP_INSTR;
        instr_v_q_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a small in-order bus model returns instr = addr ^ 32'hC0DE_0000 one cycle after grant.
module tb_ifetch;

  logic        clk;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_adr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_v_q_i;
  logic [31:0] branch_target_q_i;
  logic        trap_v_i;
  logic [31:0] trap_target_i;
  logic        dec_stall_i;
  logic [31:0] instr_q_o;
  logic [31:0] pc0_q_o;
  logic        instr_v_q_o;
  logic        instr_misaligned_q_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          resp_en;
  logic [31:0] pend [$];

  ifetch dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .imem_req_o           (imem_req_o),
    .imem_adr_o           (imem_adr_o),
    .imem_gnt_i           (imem_gnt_i),
    .imem_rvalid_i        (imem_rvalid_i),
    .imem_rdata_i         (imem_rdata_i),
    .branch_v_q_i         (branch_v_q_i),
    .branch_target_q_i    (branch_target_q_i),
    .trap_v_i             (trap_v_i),
    .trap_target_i        (trap_target_i),
    .dec_stall_i          (dec_stall_i),
    .instr_q_o            (instr_q_o),
    .pc0_q_o              (pc0_q_o),
    .instr_v_q_o          (instr_v_q_o),
    .instr_misaligned_q_o (instr_misaligned_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_resp();
    if (resp_en && pend.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend[0] ^ 32'hC0DE_0000;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
  endtask

  // One clock: sample handshakes mid-cycle, update the bus model at the edge, drive the next response.
  task automatic tick();
    logic        g;
    logic        r;
    logic [31:0] a;
    @(negedge clk);
    g = imem_req_o & imem_gnt_i;
    r = imem_rvalid_i;
    a = imem_adr_o;
    @(posedge clk);
    if (r && pend.size() > 0) void'(pend.pop_front());
    if (g) pend.push_back(a);
    #1;
    drive_resp();
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    imem_gnt_i        = 1'b0;
    branch_v_q_i      = 1'b0;
    branch_target_q_i = 32'h0;
    trap_v_i          = 1'b0;
    trap_target_i     = 32'h0;
    dec_stall_i       = 1'b0;
    resp_en           = 1'b0;
    imem_rvalid_i     = 1'b0;
    imem_rdata_i      = 32'h0;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req",   imem_req_o, 0);
    check_eq("rst_adr",   imem_adr_o, 32'h0);
    check_eq("rst_instr", instr_q_o, 32'h0000_0013);
    check_eq("rst_pc0",   pc0_q_o, 32'h0);
    check_eq("rst_v",     instr_v_q_o, 0);
    check_eq("rst_mis",   instr_misaligned_q_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("req_before_edge", imem_req_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    #2;

    // Streaming fetch straight out of reset
    do_reset();
    imem_gnt_i = 1'b1;
    resp_en    = 1'b1;
    #1;
    check_eq("req_first", imem_req_o, 1);
    check_eq("adr_first", imem_adr_o, 32'h0);
    tick(); check_eq("v_after_grant", instr_v_q_o, 0);
    tick(); check_eq("v_lat2", instr_v_q_o, 1);
            check_eq("pc_0", pc0_q_o, 32'h0);
            check_eq("instr_0", instr_q_o, 32'hC0DE_0000);
    tick(); check_eq("pc_4", pc0_q_o, 32'h4);
    tick(); check_eq("pc_8", pc0_q_o, 32'h8);

    // Reset mid-stream, then decode stall parks responses 8 and 12
    do_reset();
    imem_gnt_i = 1'b1;
    resp_en    = 1'b1;
    tick(); tick(); tick();
    check_eq("st_pre", pc0_q_o, 32'h4);
    dec_stall_i = 1'b1;
    tick(); check_eq("st_hold1", pc0_q_o, 32'h4);
            check_eq("st_hold1_v", instr_v_q_o, 1);
    #1;     check_eq("st_req1", imem_req_o, 0);
    tick(); check_eq("st_hold2", pc0_q_o, 32'h4);
    #1;     check_eq("st_req2", imem_req_o, 0);
    tick(); check_eq("st_hold3", pc0_q_o, 32'h4);
    dec_stall_i = 1'b0;
    #1;     check_eq("st_req_full", imem_req_o, 0);
    tick(); check_eq("st_pc8", pc0_q_o, 32'h8);
            check_eq("st_instr8", instr_q_o, 32'hC0DE_0008);
    tick(); check_eq("st_pc12", pc0_q_o, 32'hC);
    tick(); check_eq("st_pc16", pc0_q_o, 32'h10);

    // Branch with two requests outstanding; one response lands in the redirect cycle
    resp_en = 1'b0;
    drive_resp();
    #1;     check_eq("br_req_pre", imem_req_o, 1);
            check_eq("br_adr_pre", imem_adr_o, 32'h18);
    tick(); check_eq("br_bubble_v", instr_v_q_o, 0);
            check_eq("br_bubble_pc", pc0_q_o, 32'h10);
    #1;     check_eq("br_req_2inflight", imem_req_o, 0);
    branch_v_q_i      = 1'b1;
    branch_target_q_i = 32'h100;
    resp_en           = 1'b1;
    drive_resp();
    tick();
    branch_v_q_i = 1'b0;
    #1;     check_eq("br_req", imem_req_o, 1);
            check_eq("br_adr", imem_adr_o, 32'h100);
    tick(); check_eq("br_dropped", instr_v_q_o, 0);
    tick(); check_eq("br_v", instr_v_q_o, 1);
            check_eq("br_pc", pc0_q_o, 32'h100);
            check_eq("br_instr", instr_q_o, 32'hC0DE_0100);

    // Trap and branch together: trap wins, no request in the redirect cycle
    trap_v_i          = 1'b1;
    trap_target_i     = 32'h200;
    branch_v_q_i      = 1'b1;
    branch_target_q_i = 32'h100;
    #1;     check_eq("tr_req_redirect", imem_req_o, 0);
    tick();
    trap_v_i     = 1'b0;
    branch_v_q_i = 1'b0;
            check_eq("tr_bubble_v", instr_v_q_o, 0);
            check_eq("tr_pc_hold", pc0_q_o, 32'h100);
    #1;     check_eq("tr_adr", imem_adr_o, 32'h200);
    tick(); tick();
            check_eq("tr_v", instr_v_q_o, 1);
            check_eq("tr_pc", pc0_q_o, 32'h200);

    // PC wraps past the top of the address space
    branch_v_q_i      = 1'b1;
    branch_target_q_i = 32'hFFFF_FFFC;
    tick();
    branch_v_q_i = 1'b0;
    #1;     check_eq("wrap_adr_top", imem_adr_o, 32'hFFFF_FFFC);
    tick();
    #1;     check_eq("wrap_adr", imem_adr_o, 32'h0);
    tick(); check_eq("wrap_pc_top", pc0_q_o, 32'hFFFF_FFFC);
            check_eq("wrap_instr", instr_q_o, 32'h3F21_FFFC);
    tick(); check_eq("wrap_pc0", pc0_q_o, 32'h0);

    // Misaligned branch target
    branch_v_q_i      = 1'b1;
    branch_target_q_i = 32'h102;
    tick();
    branch_v_q_i = 1'b0;
`ifdef IFETCH_MISALIGN_EXC_EN
    check_eq("mis_flag", instr_misaligned_q_o, 1);
    check_eq("mis_pc", pc0_q_o, 32'h102);
    check_eq("mis_v", instr_v_q_o, 0);
    check_eq("mis_instr", instr_q_o, 32'h0000_0013);
    #1;     check_eq("mis_req1", imem_req_o, 0);
    tick(); check_eq("mis_flag_once", instr_misaligned_q_o, 0);
    #1;     check_eq("mis_req2", imem_req_o, 0);
    branch_v_q_i      = 1'b1;
    branch_target_q_i = 32'h100;
    tick();
    branch_v_q_i = 1'b0;
`else
    check_eq("mis_flag", instr_misaligned_q_o, 0);
    check_eq("mis_v", instr_v_q_o, 0);
`endif
    #1;     check_eq("mis_req_tgt", imem_req_o, 1);
            check_eq("mis_adr_tgt", imem_adr_o, 32'h100);
    tick(); tick();
            check_eq("mis_resume_v", instr_v_q_o, 1);
            check_eq("mis_resume_pc", pc0_q_o, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
